// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared defaults, types and helpers for the booth multiplier arbiter.
package mult_arb_pkg;
   localparam int DEF_WIDTH      = 32;
   localparam int DEF_RESP_DEPTH = 2;
   localparam int CRED_W         = $clog2(DEF_RESP_DEPTH + 1);
   localparam int STAT_W         = 16;
   typedef logic tag_t;
   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      tag_t                 tag;
   } s1_t;
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/mult_booth_core.sv
// mult_booth_core: combinational signed radix-4 Booth multiplier (WIDTH must be even).
module mult_booth_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_p
);
   logic [2*WIDTH-1:0] w_ae, w_pp;
   logic [WIDTH:0]     w_bx;
   logic [2:0]         w_d;
   assign w_ae = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_bx = {i_b, 1'b0};
   always_comb begin
      o_p  = '0;
      w_d  = '0;
      w_pp = '0;
      for (int k = 0; k < WIDTH; k += 2) begin
         w_d  = w_bx[k +: 3];
         w_pp = (w_d == 3'b001 || w_d == 3'b010) ? w_ae :
                (w_d == 3'b011) ? (w_ae << 1) :
                (w_d == 3'b100) ? -(w_ae << 1) :
                (w_d == 3'b101 || w_d == 3'b110) ? -w_ae : '0;
         o_p  = o_p + (w_pp << k);
      end
   end
endmodule

// File: rtl/mult_resp_fifo.sv
// mult_resp_fifo: synchronous FIFO; a pop and push in the same cycle while full is a pop-then-push.
module mult_resp_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_empty,
   output logic         o_full,
   output logic [W-1:0] o_head
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt;
   logic          w_pop, w_push;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == CW'(DEPTH);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   // head reads zero when empty so a stale slot never reaches the port
   assign o_head  = o_empty ? '0 : r_mem[r_rd];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
         if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   always_ff @(posedge i_clk)
      if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: two-requester round-robin front end sharing one Booth multiplier, credit-issued.
// Optional MULT_ARB_STATS_EN adds saturating per-requester accept counters.
module booth_mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req_valid_0,
   input  logic               i_req_valid_1,
   output logic               o_req_ready_0,
   output logic               o_req_ready_1,
   input  logic [WIDTH-1:0]   i_req_a_0,
   input  logic [WIDTH-1:0]   i_req_a_1,
   input  logic [WIDTH-1:0]   i_req_b_0,
   input  logic [WIDTH-1:0]   i_req_b_1,
   output logic               o_resp_valid_0,
   output logic               o_resp_valid_1,
   input  logic               i_resp_ready_0,
   input  logic               i_resp_ready_1,
   output logic [2*WIDTH-1:0] o_resp_p_0,
   output logic [2*WIDTH-1:0] o_resp_p_1
`ifdef MULT_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]  o_gnt_cnt_0,
   output logic [STAT_W-1:0]  o_gnt_cnt_1
`endif
);
   localparam int CW = $clog2(RESP_DEPTH + 1);
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      tag_t             tag;
   } stage1_t;
   stage1_t            r_s1;
   logic               r_s1_v, r_last;
   logic [CW-1:0]      r_cred_0, r_cred_1;
   logic               w_elig_0, w_elig_1, w_gnt_0, w_gnt_1, w_acc;
   logic               w_push_0, w_push_1, w_pop_0, w_pop_1;
   logic               w_empty_0, w_empty_1, w_full_0, w_full_1;
   logic [2*WIDTH-1:0] w_prod;
   // r_last holds the last granted requester; ties go to the other one
   always_comb begin
      w_elig_0 = i_req_valid_0 && (r_cred_0 < CW'(RESP_DEPTH));
      w_elig_1 = i_req_valid_1 && (r_cred_1 < CW'(RESP_DEPTH));
      w_gnt_0  = i_rst_n && w_elig_0 && (!w_elig_1 || r_last);
      w_gnt_1  = i_rst_n && w_elig_1 && (!w_elig_0 || !r_last);
   end
   assign o_req_ready_0  = w_gnt_0;
   assign o_req_ready_1  = w_gnt_1;
   assign w_acc          = w_gnt_0 || w_gnt_1;
   assign o_resp_valid_0 = !w_empty_0;
   assign o_resp_valid_1 = !w_empty_1;
   assign w_pop_0        = o_resp_valid_0 && i_resp_ready_0;
   assign w_pop_1        = o_resp_valid_1 && i_resp_ready_1;
   assign w_push_0       = r_s1_v && (r_s1.tag == 1'b0);
   assign w_push_1       = r_s1_v && (r_s1.tag == 1'b1);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_s1_v   <= 1'b0;
         r_s1     <= '0;
         r_last   <= 1'b1;
         r_cred_0 <= '0;
         r_cred_1 <= '0;
      end else begin
         r_s1_v <= w_acc;
         if (w_acc) begin
            r_s1   <= '{a: w_gnt_1 ? i_req_a_1 : i_req_a_0, b: w_gnt_1 ? i_req_b_1 : i_req_b_0, tag: w_gnt_1};
            r_last <= w_gnt_1;
         end
         r_cred_0 <= r_cred_0 + CW'(w_gnt_0) - CW'(w_pop_0);
         r_cred_1 <= r_cred_1 + CW'(w_gnt_1) - CW'(w_pop_1);
      end
   mult_booth_core #(.WIDTH(WIDTH)) u_core (
      .i_a (r_s1.a),
      .i_b (r_s1.b),
      .o_p (w_prod)
   );
   mult_resp_fifo #(.W(2*WIDTH), .DEPTH(RESP_DEPTH)) u_fifo_0 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push_0),
      .i_data  (w_prod),
      .i_pop   (w_pop_0),
      .o_empty (w_empty_0),
      .o_full  (w_full_0),
      .o_head  (o_resp_p_0)
   );
   mult_resp_fifo #(.W(2*WIDTH), .DEPTH(RESP_DEPTH)) u_fifo_1 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push_1),
      .i_data  (w_prod),
      .i_pop   (w_pop_1),
      .o_empty (w_empty_1),
      .o_full  (w_full_1),
      .o_head  (o_resp_p_1)
   );
   // credits must make a write into a full FIFO impossible
   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push_0 && w_full_0 && !w_pop_0));
   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push_1 && w_full_1 && !w_pop_1));
`ifdef MULT_ARB_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_gnt_cnt_0 <= '0;
         o_gnt_cnt_1 <= '0;
      end else begin
         if (w_gnt_0) o_gnt_cnt_0 <= sat_inc(o_gnt_cnt_0);
         if (w_gnt_1) o_gnt_cnt_1 <= sat_inc(o_gnt_cnt_1);
      end
`endif
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: randomized self-checking bench against a queue-based transaction model.
module tb_booth_mult_arbiter;
   localparam int W = 32;
   localparam int D = 2;
   logic          clk = 0, rst_n = 0;
   logic          v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
   logic [W-1:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic          rdy0, rdy1, rv0, rv1;
   logic [2*W-1:0] p0, p1;
`ifdef MULT_ARB_STATS_EN
   logic [15:0]   gc0, gc1;
`endif
   int total = 0, bad = 0;

   logic [63:0] q0p[$], q1p[$];
   int          q0t[$], q1t[$];
   int          n;
   bit          last;
   bit          eg0, eg1, ev0, ev1;
   logic [63:0] ep0, ep1;

   always #5 clk = ~clk;

   booth_mult_arbiter dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid_0  (v0),
      .i_req_valid_1  (v1),
      .o_req_ready_0  (rdy0),
      .o_req_ready_1  (rdy1),
      .i_req_a_0      (a0),
      .i_req_a_1      (a1),
      .i_req_b_0      (b0),
      .i_req_b_1      (b1),
      .o_resp_valid_0 (rv0),
      .o_resp_valid_1 (rv1),
      .i_resp_ready_0 (rr0),
      .i_resp_ready_1 (rr1),
      .o_resp_p_0     (p0),
      .o_resp_p_1     (p1)
`ifdef MULT_ARB_STATS_EN
      ,
      .o_gnt_cnt_0    (gc0),
      .o_gnt_cnt_1    (gc1)
`endif
   );

   function automatic logic [63:0] mul(input logic [31:0] x, input logic [31:0] y);
      return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
   endfunction

   function automatic logic [31:0] rnd();
      int s = $urandom_range(0, 7);
      return s == 0 ? 32'h8000_0000 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h0 :
             s == 3 ? 32'h7FFF_FFFF : 32'($urandom);
   endfunction

   // credit = number of accepted, not yet consumed ops; a product is visible one edge after its accept edge's successor
   task automatic predict();
      bit el0, el1;
      #1;
      el0 = v0 && q0p.size() < D;
      el1 = v1 && q1p.size() < D;
      eg0 = rst_n && el0 && (!el1 || last);
      eg1 = rst_n && el1 && (!el0 || !last);
      ev0 = q0p.size() > 0 && q0t[0] <= n;
      ev1 = q1p.size() > 0 && q1t[0] <= n;
      ep0 = ev0 ? q0p[0] : 64'd0;
      ep1 = ev1 ? q1p[0] : 64'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      n++;
      if (ev0 && rr0) begin void'(q0p.pop_front()); void'(q0t.pop_front()); end
      if (ev1 && rr1) begin void'(q1p.pop_front()); void'(q1t.pop_front()); end
      if (eg0) begin q0p.push_back(mul(a0, b0)); q0t.push_back(n + 1); last = 0; end
      if (eg1) begin q1p.push_back(mul(a1, b1)); q1t.push_back(n + 1); last = 1; end
      @(negedge clk);
   endtask

   task automatic model_clear();
      q0p.delete(); q1p.delete(); q0t.delete(); q1t.delete();
      n = 0;
      last = 1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic next_ops(input int pv);
      if (!v0 || eg0) begin v0 = $urandom_range(0, 99) < pv; a0 = rnd(); b0 = rnd(); end
      if (!v1 || eg1) begin v1 = $urandom_range(0, 99) < pv; a1 = rnd(); b1 = rnd(); end
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_clear();
      v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
      @(negedge clk);
      #1;
      total++;
      if ({rdy0, rdy1, rv0, rv1, p0, p1} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {rdy0, rdy1, rv0, rv1, p0, p1});
      end
      do_reset();
      predict();
      total++;
      if ({rdy0, rdy1, rv0, rv1} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_idle got=%b want=0000", {rdy0, rdy1, rv0, rv1});
      end
   endtask

   task automatic test_single();
      do_reset();
      v0 = 1; a0 = 32'd3; b0 = 32'hFFFF_FFFB;
      predict();
      total++;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", rdy0); end
      tick();
      v0 = 0;
      predict();
      total++;
      if (rv0 !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", rv0); end
      tick();
      predict();
      total++;
      if (rv0 !== 1'b1 || p0 !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         bad++;
         $display("FAIL single_prod got=%b/%h want=1/fffffffffffffff1", rv0, p0);
      end
      rr0 = 1;
      tick();
      predict();
      total++;
      if (rv0 !== 1'b0 || p0 !== 64'd0) begin bad++; $display("FAIL single_pop got=%b/%h want=0/0", rv0, p0); end
   endtask

   task automatic test_tie();
      do_reset();
      rr0 = 1; rr1 = 1;
      v0 = 1; v1 = 1; a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
      for (int k = 0; k < 16; k++) begin
         predict();
         total++;
         if (rdy0 !== (k % 2 == 0) || rdy1 !== (k % 2 == 1)) begin
            bad++;
            $display("FAIL tie_alt cyc=%0d got=%b%b want=%b%b", k, rdy0, rdy1, k % 2 == 0, k % 2 == 1);
         end
         total++;
         if ({rv0, rv1, p0, p1} !== {ev0, ev1, ep0, ep1}) begin
            bad++;
            $display("FAIL tie_resp cyc=%0d got=%h want=%h", k, {rv0, rv1, p0, p1}, {ev0, ev1, ep0, ep1});
         end
         tick();
         if (eg0) begin a0 = rnd(); b0 = rnd(); end
         if (eg1) begin a1 = rnd(); b1 = rnd(); end
      end
   endtask

   task automatic test_credit_block();
      do_reset();
      v1 = 1; a1 = rnd(); b1 = rnd();
      for (int k = 0; k < 8; k++) begin
         predict();
         total++;
         if (rdy1 !== (k < 2) || rdy0 !== 1'b0) begin
            bad++;
            $display("FAIL credit_block cyc=%0d got=%b want=%b", k, rdy1, k < 2);
         end
         tick();
         if (eg1) begin a1 = rnd(); b1 = rnd(); end
      end
      rr1 = 1;
      predict();
      total++;
      if (rv1 !== 1'b1 || rdy1 !== 1'b0 || p1 !== ep1) begin
         bad++;
         $display("FAIL credit_pop got=%b%b/%h want=10/%h", rv1, rdy1, p1, ep1);
      end
      tick();
      rr1 = 0;
      for (int k = 0; k < 4; k++) begin
         predict();
         total++;
         if (rdy1 !== (k == 0)) begin
            bad++;
            $display("FAIL credit_reopen cyc=%0d got=%b want=%b", k, rdy1, k == 0);
         end
         tick();
         if (eg1) begin a1 = rnd(); b1 = rnd(); end
      end
   endtask

   task automatic test_extremes();
      logic [63:0] want0 [3];
      logic [63:0] want1 [3];
      do_reset();
      rr0 = 1; rr1 = 1;
      v0 = 1; a0 = 32'h8000_0000; b0 = 32'h8000_0000;
      v1 = 1; a1 = 32'h7FFF_FFFF; b1 = 32'h8000_0000;
      want0 = '{64'd0, 64'd0, 64'h4000_0000_0000_0000};
      want1 = '{64'd0, 64'd0, 64'd0};
      for (int k = 0; k < 3; k++) begin
         predict();
         total++;
         if (p0 !== want0[k]) begin bad++; $display("FAIL ext_p0 cyc=%0d got=%h want=%h", k, p0, want0[k]); end
         tick();
         if (eg0) v0 = 0;
         if (eg1) v1 = 0;
      end
      predict();
      total++;
      if (rv1 !== 1'b1 || p1 !== 64'hC000_0000_8000_0000) begin
         bad++;
         $display("FAIL ext_p1 got=%b/%h want=1/c000000080000000", rv1, p1);
      end
      tick();
      v0 = 1; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF;
      predict();
      tick();
      v0 = 0;
      predict();
      tick();
      predict();
      total++;
      if (rv0 !== 1'b1 || p0 !== 64'd1) begin bad++; $display("FAIL ext_neg1 got=%b/%h want=1/1", rv0, p0); end
      total++;
      if (want1[0] !== 64'd0 || p1 !== 64'd0) begin bad++; $display("FAIL ext_p1_drain got=%h want=0", p1); end
      tick();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      v0 = 1; a0 = rnd(); b0 = rnd();
      predict();
      tick();
      v0 = 0;
      rst_n = 0;
      #1;
      total++;
      if ({rdy0, rdy1, rv0, rv1, p0, p1} !== '0) begin
         bad++;
         $display("FAIL midreset_out got=%h want=0", {rdy0, rdy1, rv0, rv1, p0, p1});
      end
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      rr0 = 1;
      for (int k = 0; k < 4; k++) begin
         predict();
         total++;
         if (rv0 !== 1'b0 || p0 !== 64'd0) begin bad++; $display("FAIL midreset_ghost cyc=%0d got=%b/%h want=0/0", k, rv0, p0); end
         tick();
      end
      rr0 = 0;
      v0 = 1; a0 = 32'd7; b0 = 32'd6;
      predict();
      tick();
      v0 = 0;
      predict();
      tick();
      predict();
      total++;
      if (rv0 !== 1'b1 || p0 !== 64'd42) begin bad++; $display("FAIL midreset_next got=%b/%h want=1/2a", rv0, p0); end
   endtask

   task automatic test_random();
      int to_ok;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rr0 = $urandom_range(0, 2) != 0;
         rr1 = $urandom_range(0, 3) == 0;
         predict();
         total++;
         if ({rdy0, rdy1, rv0, rv1, p0, p1} !== {eg0, eg1, ev0, ev1, ep0, ep1}) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h want=%h", k, {rdy0, rdy1, rv0, rv1, p0, p1}, {eg0, eg1, ev0, ev1, ep0, ep1});
         end
         tick();
         next_ops(60);
      end
      v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
      to_ok = 0;
      for (int k = 0; k < 20; k++) begin
         predict();
         if (!rv0 && !rv1 && q0p.size() == 0 && q1p.size() == 0) begin to_ok = 1; break; end
         tick();
      end
      total++;
      if (to_ok != 1) begin bad++; $display("FAIL random_drain got=%b%b want=00 within 20 cycles", rv0, rv1); end
   endtask

`ifdef MULT_ARB_STATS_EN
   task automatic test_stats();
      int acc = 0;
      do_reset();
      #1;
      total++;
      if (gc0 !== 16'd0 || gc1 !== 16'd0) begin bad++; $display("FAIL stats_reset got=%h/%h want=0/0", gc0, gc1); end
      v0 = 1; rr0 = 1;
      for (int k = 0; k < 120000 && acc < 70000; k++) begin
         #1;
         if (rdy0) acc++;
         @(negedge clk);
      end
      v0 = 0;
      @(negedge clk);
      total++;
      if (acc < 70000 || gc0 !== 16'hFFFF || gc1 !== 16'd0) begin
         bad++;
         $display("FAIL stats_sat accepts=%0d got=%h/%h want=ffff/0", acc, gc0, gc1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_credit_block();
      test_extremes();
      test_reset_midflight();
      test_random();
`ifdef MULT_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Two-requester round-robin arbiter that time-shares one combinational signed 32x32 Booth multiplier core. It sits between two independent requesters and the core. It accepts operand pairs over valid/ready handshakes and registers the operands before the core. It returns each 64-bit product to the originating requester through a per-requester response FIFO, using credit-based issue so responses never overflow.

## Interface
Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH
- RESP_DEPTH, 2, entries per response FIFO; also the max outstanding ops per requester

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid_0 / req_valid_1  in  1  requester operand pair valid
- req_ready_0 / req_ready_1  out  1  operand pair accepted this cycle
- req_a_0 / req_a_1  in  WIDTH  multiplicand, signed two's complement
- req_b_0 / req_b_1  in  WIDTH  multiplier, signed two's complement
- resp_valid_0 / resp_valid_1  out  1  product available
- resp_ready_0 / resp_ready_1  in  1  requester consumes product
- resp_p_0 / resp_p_1  out  2*WIDTH  signed product
- gnt_cnt_0 / gnt_cnt_1  out  16  saturating accept counters; present only with MULT_ARB_STATS_EN

## Operation
- Eligibility:
  - requester i is eligible when req_valid_i=1 and credit_i < RESP_DEPTH.
  - credit_i counts accepted-but-unconsumed ops, whether in flight or buffered.
- Arbitration:
  - at most one grant per cycle.
  - if only one requester is eligible, it is granted.
  - if both are eligible, the requester that was not granted last wins.
  - last_gnt updates only on an accept.
- req_ready_i is combinational and equals grant_i. Accept means req_valid_i & req_ready_i at a rising edge.
- Requester rule: after asserting req_valid_i, the requester holds req_valid_i and its operands stable until accepted.
- Stage 1:
  - on accept, register {a, b, tag=i}; stage-1 valid is set.
  - if no accept, stage-1 valid is cleared.
- Core: product = signed(a)*signed(b), full 2*WIDTH bits, no truncation or rounding. Examples: -1*-1 = 1, 0x80000000*0x80000000 = 0x4000_0000_0000_0000.
- Stage 2: when stage-1 valid, write the product into FIFO[tag] on the next edge. The write never stalls; credits guarantee free space.
- Response:
  - resp_valid_i = FIFO_i not empty; resp_p_i = FIFO_i head.
  - pop on resp_valid_i & resp_ready_i.
  - FIFO order is in-order per requester.
- Credit update:
  - +1 on accept of i; -1 on pop of i.
  - if both happen in the same cycle, the credit is unchanged.
- Boundary conditions:
  - simultaneous FIFO push and pop is legal when full, as a pop-then-push.
  - credit_i = RESP_DEPTH forces req_ready_i = 0 even if the other requester is idle.
  - resp_ready_i while resp_valid_i = 0 is ignored.

## Timing
- Accept at edge T; product written to FIFO at edge T+1; resp_valid visible in the cycle after T+1. Latency is 2 edges.
- Throughput: one accept per cycle aggregate. Sustained per-requester rate is bounded by RESP_DEPTH and consumer speed.
- Reset, asserted at any time including mid-operation:
  - stage-1 valid = 0, all FIFOs empty, all credits = 0.
  - last_gnt = 1, so requester 0 wins the first tie.
  - every req_ready, resp_valid, resp_p and gnt_cnt output = 0.
  - in-flight operations are discarded.
- No combinational path from resp_ready to req_ready other than through registered credits.

## Configuration
- MULT_ARB_STATS_EN
  - defined: gnt_cnt_0/1 ports exist. Each increments on an accept of its requester and saturates at 0xFFFF. Reset value is 0.
  - undefined: the ports and counters are absent. Arbitration and datapath are identical in both builds.

## Structure
- Package mult_arb_pkg holds:
  - WIDTH and RESP_DEPTH defaults
  - the tag typedef (1 bit)
  - the credit width, $clog2(RESP_DEPTH+1)
  - STAT_W = 16
  - the stage-1 struct {a, b, tag}
- Sub-module mult_resp_fifo: parameterized synchronous FIFO with push/pop/empty/full/head and the same async active-low reset. It is instantiated once per requester.
- The Booth core is instantiated once, combinational, between stage 1 and the FIFOs.

## Test plan
- Single op: after reset, req 0 sends a=3, b=-5 → req_ready_0=1 in the same cycle; resp_p_0=0xFFFF_FFFF_FFFF_FFF1 with resp_valid_0 two edges later.
- Tie: both valid every cycle with resp_ready high → grants alternate 0,1,0,1; products return in order to the correct port.
- Credit block: req 1 streams with resp_ready_1=0 → exactly 2 accepts, then req_ready_1 stays 0. One pop re-enables a single accept.
- Extremes: 0x80000000*0x80000000 → 0x4000_0000_0000_0000. 0x7FFFFFFF*0x80000000 → 0xC000_0000_8000_0000.
- Reset mid-flight: assert reset one cycle after an accept → no resp_valid ever appears for that op; outputs read 0; the next op completes normally.
- Stats (MULT_ARB_STATS_EN): 70000 accepts on req 0 → gnt_cnt_0 = 0xFFFF, gnt_cnt_1 = 0.
